// File: rtl/mdio_master_mp.sv
// mdio_master_mp
//   Clause 22 MDIO management master shared across NUM_PORTS PHY management
//   ports. One frame is in flight at a time, on the port named by the
//   command. Every other port idles with mdc=0, mdio_out=1 and mdio_oen=1.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_write             1 = write frame, 0 = read frame
//   cmd_port              target management port
//   cmd_phyad, cmd_regad  PHY and register address
//   cmd_wdata             write data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    read data (0 for writes) and error flag; both hold
//                         their values until the next rsp_valid
//   mdc, mdio_out         per-port management clock and serial data out
//   mdio_oen              per-port output disable (1 = pad tristated)
//   mdio_in               per-port serial data in
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// PRE    | 32 preamble ones
// HDR    | ST, OP, PHYAD, REGAD (14 bits)
// TA     | turnaround (2 bits)
// DATA   | 16 data bits
// DONE   | rsp_valid pulse, back to IDLE next cycle
module mdio_master_mp #(
  parameter int NUM_PORTS   = 2,
  parameter int CLK_DIV     = 20,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [2:0]           cmd_port,
  input  logic [4:0]           cmd_phyad,
  input  logic [4:0]           cmd_regad,
  input  logic [15:0]          cmd_wdata,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_PORTS-1:0] mdc,
  output logic [NUM_PORTS-1:0] mdio_out,
  output logic [NUM_PORTS-1:0] mdio_oen,
  input  logic [NUM_PORTS-1:0] mdio_in
);

  localparam int             DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]     NP       = 4'(NUM_PORTS);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

  state_t               state_q;
  logic                 ready_q;
  logic                 wr_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic [31:0]          tx_q;
  logic [15:0]          rx_q;
  logic [4:0]           cnt_q;
  logic [DW-1:0]        div_q;
  logic                 high_q;
  logic                 ta_err_q;
  logic [NUM_PORTS-1:0] mdc_q;
  logic [NUM_PORTS-1:0] out_q;
  logic [NUM_PORTS-1:0] oen_q;
  logic                 rsp_valid_q;
  logic [15:0]          rdata_q;
  logic                 err_q;

  logic [NUM_PORTS-1:0] sel_mask_d;
  logic                 port_ok_d;
  logic                 accept_d;
  logic                 in_bit_d;
  logic                 tick_d;
  logic [31:0]          frame_d;

  always_comb begin
    sel_mask_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) sel_mask_d[p] = (cmd_port == 3'(p));
  end

  assign port_ok_d = ({1'b0, cmd_port} < NP);
  assign accept_d  = cmd_valid & ready_q;
  // mask_q is one-hot, so this picks the selected port's input without a wide index
  assign in_bit_d  = |(mdio_in & mask_q);
  assign tick_d    = (div_q == '0);
  // A read transmits ones through TA and data; the pad is tristated then anyway
  assign frame_d   = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad, cmd_regad,
                      (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};

  // Selected port carries bit b, every other port idles high
  function automatic logic [NUM_PORTS-1:0] drive_vec(input logic [NUM_PORTS-1:0] m,
                                                     input logic b);
    return ~m | (m & {NUM_PORTS{b}});
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      wr_q        <= 1'b0;
      mask_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      high_q      <= 1'b0;
      ta_err_q    <= 1'b0;
      mdc_q       <= '0;
      out_q       <= '1;
      oen_q       <= '1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept_d) begin
            ready_q <= 1'b0;
            if (!port_ok_d) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rdata_q     <= '0;
              err_q       <= 1'b1;
            end else begin
              wr_q     <= cmd_write;
              mask_q   <= sel_mask_d;
              tx_q     <= frame_d;
              div_q    <= DIV_LAST;
              high_q   <= 1'b0;
              ta_err_q <= 1'b0;
              mdc_q    <= '0;
              oen_q    <= ~sel_mask_d;
              if (PREAMBLE_EN) begin
                state_q <= S_PRE;
                cnt_q   <= 5'd31;
                out_q   <= drive_vec(sel_mask_d, 1'b1);
              end else begin
                state_q <= S_HDR;
                cnt_q   <= 5'd13;
                out_q   <= drive_vec(sel_mask_d, frame_d[31]);
              end
            end
          end
        end
        S_PRE, S_HDR, S_TA, S_DATA: begin
          if (!tick_d) begin
            div_q <= div_q - 1'b1;
          end else begin
            div_q  <= DIV_LAST;
            high_q <= ~high_q;
            if (!high_q) begin
              // rising MDC: the PHY samples our bit, we sample the PHY's
              mdc_q <= mask_q;
              if (state_q == S_DATA) rx_q <= {rx_q[14:0], in_bit_d};
              if (state_q == S_TA && cnt_q == '0 && !wr_q && in_bit_d) ta_err_q <= 1'b1;
            end else begin
              // end of a bit: MDC falls and the next bit goes out
              mdc_q <= '0;
              cnt_q <= cnt_q - 1'b1;
              if (state_q != S_PRE) tx_q <= {tx_q[30:0], 1'b0};
              case (state_q)
                S_PRE: begin
                  if (cnt_q == '0) begin
                    state_q <= S_HDR;
                    cnt_q   <= 5'd13;
                    out_q   <= drive_vec(mask_q, tx_q[31]);
                  end else begin
                    out_q <= drive_vec(mask_q, 1'b1);
                  end
                end
                S_HDR: begin
                  out_q <= drive_vec(mask_q, tx_q[30]);
                  if (cnt_q == '0) begin
                    state_q <= S_TA;
                    cnt_q   <= 5'd1;
                    if (!wr_q) oen_q <= '1;
                  end
                end
                S_TA: begin
                  out_q <= drive_vec(mask_q, tx_q[30]);
                  if (cnt_q == '0) begin
                    state_q <= S_DATA;
                    cnt_q   <= 5'd15;
                  end
                end
                S_DATA: begin
                  out_q <= drive_vec(mask_q, tx_q[30]);
                  if (cnt_q == '0) begin
                    state_q     <= S_DONE;
                    out_q       <= '1;
                    oen_q       <= '1;
                    rsp_valid_q <= 1'b1;
                    rdata_q     <= wr_q ? 16'h0000 : rx_q;
                    err_q       <= wr_q ? 1'b0 : ta_err_q;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mdc       = mdc_q;
  assign mdio_out  = out_q;
  assign mdio_oen  = oen_q;

endmodule

// File: tb/tb_mdio_master_mp.sv
module tb_mdio_master_mp;

  localparam int NP = 2;
  localparam int CD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [2:0]    cmd_port;
  logic [4:0]    cmd_phyad, cmd_regad;
  logic [15:0]   cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [15:0]   rsp_rdata;
  logic [NP-1:0] mdc, mdio_out, mdio_oen, mdio_in;

  logic        b_valid, b_ready, b_write;
  logic [2:0]  b_port;
  logic [4:0]  b_phyad, b_regad;
  logic [15:0] b_wdata;
  logic        b_rsp_valid, b_rsp_err;
  logic [15:0] b_rsp_rdata;
  logic [0:0]  b_mdc, b_out, b_oen, b_in;

  mdio_master_mp #(.NUM_PORTS(NP), .CLK_DIV(CD), .PREAMBLE_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_port(cmd_port), .cmd_phyad(cmd_phyad),
    .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mdc(mdc), .mdio_out(mdio_out),
    .mdio_oen(mdio_oen), .mdio_in(mdio_in));

  mdio_master_mp #(.NUM_PORTS(1), .CLK_DIV(2), .PREAMBLE_EN(1'b0)) dut_np (
    .clk(clk), .reset_n(reset_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_write(b_write), .cmd_port(b_port), .cmd_phyad(b_phyad),
    .cmd_regad(b_regad), .cmd_wdata(b_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .mdc(b_mdc), .mdio_out(b_out),
    .mdio_oen(b_oen), .mdio_in(b_in));

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    bit          wr;
    logic [2:0]  port;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic [15:0] pdata;   // what the PHY returns on a read
    bit          ta2;     // PHY level on the second turnaround bit
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Serial stream the frame must carry, bit 63 first
  function automatic logic [63:0] model_stream(input bit wr, input logic [4:0] phy,
                                               input logic [4:0] rg, input logic [15:0] wd);
    return {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rg, 2'b10, wd};
  endfunction

  // PHY line level for frame bit i (pull-up wherever the PHY does not drive)
  function automatic logic phybit(input int i, input logic [15:0] d, input logic t2);
    if (i == 47) return t2;
    if (i >= 48 && i < 64) return d[63-i];
    return 1'b1;
  endfunction

  function automatic vec_t with_model(input vec_t v);
    vec_t r = v;
    if (v.port >= NP) begin r.exp_rdata = 16'h0; r.exp_err = 1'b1; end
    else if (v.wr)    begin r.exp_rdata = 16'h0; r.exp_err = 1'b0; end
    else              begin r.exp_rdata = v.pdata; r.exp_err = v.ta2; end
    return r;
  endfunction

  // Call at a negedge. Issues v, follows the whole frame, checks everything.
  // With hold_next, cmd_valid stays high after accept carrying nxt.
  task automatic do_frame(input vec_t v, input bit hold_next, input vec_t nxt, input string tag);
    logic [63:0] cap_out, cap_oen, exp_s, msk, exp_oen;
    logic [NP-1:0] pmdc, pout;
    int nbits, cyc, lat, idle_bad, chg_bad, ready_busy;
    bit got, vp;
    logic [15:0] rd;
    logic er;
    vp = (v.port < NP);
    exp_s   = model_stream(v.wr, v.phy, v.rg, v.wd);
    msk     = v.wr ? {64{1'b1}} : ~64'h3FFFF;
    exp_oen = v.wr ? 64'h0 : 64'h3FFFF;
    cap_out = '0; cap_oen = '0; nbits = 0; lat = -1; idle_bad = 0; chg_bad = 0;
    ready_busy = 0; got = 0; rd = 'x; er = 1'bx;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_port = v.port;
    cmd_phyad = v.phy; cmd_regad = v.rg; cmd_wdata = v.wd;
    mdio_in = '1;
    cyc = 0;
    while (!cmd_ready && cyc < 2000) begin @(negedge clk); cyc++; end
    check({tag, " ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    if (hold_next) begin
      cmd_write = nxt.wr; cmd_port = nxt.port; cmd_phyad = nxt.phy;
      cmd_regad = nxt.rg; cmd_wdata = nxt.wd;
    end else begin
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_port = 3'($urandom);
      cmd_phyad = 5'($urandom); cmd_regad = 5'($urandom); cmd_wdata = 16'($urandom);
    end
    pmdc = mdc; pout = mdio_out; cyc = 0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin got = 1; lat = cyc - 1; rd = rsp_rdata; er = rsp_err; end
      if (cmd_ready) ready_busy++;
      for (int p = 0; p < NP; p++)
        if (!(vp && p == int'(v.port)))
          if (mdc[p] !== 1'b0 || mdio_out[p] !== 1'b1 || mdio_oen[p] !== 1'b1) idle_bad++;
      if (vp) begin
        int sp = int'(v.port);
        if (mdio_out[sp] !== pout[sp] && !(pmdc[sp] && !mdc[sp]) && cyc > 1) chg_bad++;
        if (mdc[sp] && !pmdc[sp]) begin
          cap_out = {cap_out[62:0], mdio_out[sp]};
          cap_oen = {cap_oen[62:0], mdio_oen[sp]};
          nbits++;
          mdio_in[sp] = phybit(nbits, v.pdata, v.ta2);
        end
      end
      pmdc = mdc; pout = mdio_out;
    end
    check({tag, " rsp_valid seen"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(lat), vp ? 64'd512 : 64'd0);
    check({tag, " bit count"}, 64'(nbits), vp ? 64'd64 : 64'd0);
    if (vp) begin
      check({tag, " stream"}, cap_out & msk, exp_s & msk);
      check({tag, " oen"}, cap_oen, exp_oen);
    end
    check({tag, " rdata"}, 64'(rd), 64'(v.exp_rdata));
    check({tag, " err"}, 64'(er), 64'(v.exp_err));
    check({tag, " idle ports"}, 64'(idle_bad), 64'd0);
    check({tag, " mdio change off fall"}, 64'(chg_bad), 64'd0);
    check({tag, " ready while busy"}, 64'(ready_busy), 64'd0);
    @(negedge clk);
    check({tag, " pulse width"}, 64'(rsp_valid), 64'd0);
    check({tag, " rdata hold"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    check({tag, " ready after done"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd0);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, " mdc"}, 64'(mdc), 64'd0);
    check({tag, " mdio_out"}, 64'(mdio_out), 64'({NP{1'b1}}));
    check({tag, " mdio_oen"}, 64'(mdio_oen), 64'({NP{1'b1}}));
  endtask

  vec_t tbl[8];
  vec_t rnd[$];
  vec_t dummy;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_port = '0;
    cmd_phyad = '0; cmd_regad = '0; cmd_wdata = '0; mdio_in = '1;
    b_valid = 1'b0; b_write = 1'b0; b_port = '0; b_phyad = '0; b_regad = '0;
    b_wdata = '0; b_in = 1'b1;
    dummy = '{1'b0, 3'd0, 5'd0, 5'd0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0};

    //        wr    port  phy    rg     wd        pdata     ta2   exp_rdata exp_err
    tbl[0] = '{1'b1, 3'd1, 5'h01, 5'h00, 16'h8000, 16'hFFFF, 1'b1, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 3'd0, 5'h01, 5'h02, 16'h0000, 16'h0141, 1'b0, 16'h0141, 1'b0};
    tbl[2] = '{1'b1, 3'd5, 5'h03, 5'h04, 16'h1234, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
    tbl[3] = '{1'b1, 3'd0, 5'h1F, 5'h1F, 16'h5A5A, 16'hFFFF, 1'b1, 16'h0000, 1'b0};
    tbl[4] = '{1'b0, 3'd7, 5'h00, 5'h00, 16'h0000, 16'hABCD, 1'b0, 16'h0000, 1'b1};
    tbl[5] = '{1'b0, 3'd1, 5'h10, 5'h0A, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[6] = '{1'b0, 3'd2, 5'h02, 5'h03, 16'h0000, 16'h1111, 1'b0, 16'h0000, 1'b1};
    tbl[7] = '{1'b0, 3'd1, 5'h05, 5'h06, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    #1 check("ready before first edge", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("ready after first edge", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 8; i++) do_frame(tbl[i], 1'b0, dummy, $sformatf("tbl%0d", i));

    // Reset mid-frame at bit 40 of a write; no response may appear
    begin
      int rises = 0, cyc = 0, stray = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_port = 3'd1;
      cmd_phyad = 5'h09; cmd_regad = 5'h11; cmd_wdata = 16'hBEEF;
      while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
      @(posedge clk); #1 cmd_valid = 1'b0;
      cyc = 0;
      while (rises < 40 && cyc < 2000) begin
        logic pm = mdc[1];
        @(negedge clk); cyc++;
        if (mdc[1] && !pm) rises++;
      end
      check("abort reached bit 40", 64'(rises), 64'd40);
      #2 reset_n = 1'b0;
      #1 check_reset_values("abort");
      repeat (3) begin @(negedge clk); if (rsp_valid) stray++; end
      reset_n = 1'b1;
      repeat (3) begin @(negedge clk); if (rsp_valid) stray++; end
      check("abort no rsp", 64'(stray), 64'd0);
    end

    // Random frames against the model, some issued back-to-back with valid held
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v.wr = 1'($urandom);
      v.port = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      v.phy = 5'($urandom); v.rg = 5'($urandom); v.wd = 16'($urandom);
      v.pdata = 16'($urandom); v.ta2 = ($urandom_range(0, 3) == 0);
      rnd.push_back(with_model(v));
    end
    for (int i = 0; i < rnd.size(); i++) begin
      bit hold = (i + 1 < rnd.size()) && ($urandom_range(0, 1) == 1);
      do_frame(rnd[i], hold, hold ? rnd[i+1] : dummy, $sformatf("rnd%0d", i));
    end

    // Preamble-suppressed instance, CLK_DIV=2: 32-bit frame in 128 cycles
    begin
      logic [31:0] cap = '0;
      int nb = 0, cyc = 0, lat = -1;
      logic pm, er = 1'bx;
      @(negedge clk);
      b_valid = 1'b1; b_write = 1'b1; b_port = 3'd0;
      b_phyad = 5'h03; b_regad = 5'h04; b_wdata = 16'hC3A5;
      while (!b_ready && cyc < 100) begin @(negedge clk); cyc++; end
      @(posedge clk); #1 b_valid = 1'b0;
      pm = b_mdc[0]; cyc = 0;
      while (lat < 0 && cyc < 1000) begin
        @(negedge clk); cyc++;
        if (b_rsp_valid) begin lat = cyc - 1; er = b_rsp_err; end
        if (b_mdc[0] && !pm) begin cap = {cap[30:0], b_out[0]}; nb++; end
        pm = b_mdc[0];
      end
      check("nopre latency", 64'(lat), 64'd128);
      check("nopre bit count", 64'(nb), 64'd32);
      check("nopre first bits", 64'(cap[31:30]), 64'd1);
      check("nopre stream", 64'(cap), 64'({2'b01, 2'b01, 5'h03, 5'h04, 2'b10, 16'hC3A5}));
      check("nopre err", 64'(er), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mdio_master_mp.md
MDIO_MASTER_MP -- requirements
Module: mdio_master_mp

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of independent PHY management ports (1..8).
REQ-002 Parameter CLK_DIV, default 20, clk cycles per MDC half-period (>=2); 100 MHz clk gives 2.5 MHz MDC.
REQ-003 Parameter PREAMBLE_EN, default 1, 1 = send 32-bit all-ones preamble; 0 = preamble suppressed.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_write  in  1  1 = write frame, 0 = read frame.
REQ-009 cmd_port  in  3  target port index.
REQ-010 cmd_phyad  in  5  PHY address.
REQ-011 cmd_regad  in  5  register address.
REQ-012 cmd_wdata  in  16  write data.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  16  read data; 0 for writes.
REQ-015 rsp_err  out  1  error flag, valid with rsp_valid.
REQ-016 mdc  out  NUM_PORTS  per-port management clock.
REQ-017 mdio_out  out  NUM_PORTS  per-port serial data out.
REQ-018 mdio_oen  out  NUM_PORTS  per-port output disable; 1 = pad tristated.
REQ-019 mdio_in  in  NUM_PORTS  per-port serial data in.

Function
REQ-020 Frames SHALL be IEEE 802.3 Clause 22: [preamble] ST=01, OP=01 write / 10 read, PHYAD, REGAD, TA, 16 data bits, all MSB first.
REQ-021 FSM states SHALL be IDLE, PRE, HDR (ST+OP+PHYAD+REGAD, 14 bits), TA, DATA, DONE.
REQ-022 IDLE->PRE on accept if PREAMBLE_EN=1, else IDLE->HDR; PRE->HDR after 32 bits; HDR->TA after 14; TA->DATA after 2; DATA->DONE after 16; DONE->IDLE after 1 cycle.
REQ-023 cmd_ready SHALL be 1 only in IDLE; command fields SHALL be captured on the accept cycle and be don't-care afterwards.
REQ-024 Each bit SHALL be one MDC period: low phase CLK_DIV cycles, then high phase CLK_DIV cycles; first low phase starts the cycle after accept.
REQ-025 mdio_out SHALL change only at the start of a low phase; PHY samples on MDC rise.
REQ-026 Master SHALL sample mdio_in of the selected port on the clk cycle MDC goes high.
REQ-027 Only the selected port SHALL toggle mdc and drive mdio; non-selected ports hold mdc=0, mdio_out=1, mdio_oen=1.
REQ-028 Write: master drives all bits including TA=10; mdio_oen=0 for selected port from PRE/HDR start through last data bit.
REQ-029 Read: master drives through REGAD, then mdio_oen=1 for both TA bits and all data bits.
REQ-030 Read: second TA bit sampled !=0 SHALL set rsp_err=1; data still shifted in and returned.
REQ-031 rsp_valid SHALL pulse in DONE, one cycle after the last data bit high phase ends; rsp_rdata/rsp_err hold until next rsp_valid.
REQ-032 Frame length SHALL be (64 if PREAMBLE_EN else 32) x 2 x CLK_DIV cycles from accept to DONE.
REQ-033 cmd_port >= NUM_PORTS: command accepted, no MDC/MDIO activity, rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
REQ-034 cmd_valid asserted while busy SHALL be held off (cmd_ready=0), never dropped or queued internally.
REQ-035 Bit and divider counters SHALL be sized from parameters; no wrap before terminal count.

Reset
REQ-036 Reset assertion SHALL immediately force: state IDLE, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all mdc=0, all mdio_out=1, all mdio_oen=1.
REQ-037 cmd_ready SHALL rise on the first clk edge after reset_n release.
REQ-038 Reset mid-frame SHALL abort silently with no rsp_valid; next frame after release is complete and correct.

Verification
REQ-039 Write port 1, phyad=0x01, regad=0x00, wdata=0x8000, CLK_DIV=4 -> port 1 serial stream 32x1,01,01,00001,00000,10,1000000000000000; 512 cycles; rsp_valid, rsp_err=0; port 0 idle.
REQ-040 Read port 0, regad=0x02, PHY model returns TA 0 and 0x0141 -> rsp_rdata=0x0141, rsp_err=0, mdio_oen=1 from TA through data.
REQ-041 Read with no PHY (mdio_in pulled 1) -> rsp_err=1, rsp_rdata=0xFFFF.
REQ-042 PREAMBLE_EN=0, CLK_DIV=2 write -> 32-bit frame, 128 cycles to DONE, first bits 0,1.
REQ-043 cmd_port=5 with NUM_PORTS=2 -> no mdc toggles, rsp_valid next cycle, rsp_err=1.
REQ-044 reset_n low at bit 40 of a write -> outputs at reset values same cycle, no rsp_valid; back-to-back command after release completes correctly.
